// File: rtl/uart_rx_param.sv
// Parameterised UART receiver: 2-flop input synchroniser, mid-bit sampling,
// optional even/odd parity, 1 or 2 stop bits, frame/parity error flags.
module uart_rx_param #(
    parameter int CLKS_PER_BIT = 87,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 i_clock,
    input  logic                 i_reset_n,
    input  logic                 i_RX_Serial,
    output logic [DATA_BITS-1:0] o_RX_Data,
    output logic                 o_RX_Done,
    output logic                 o_Parity_Err,
    output logic                 o_Frame_Err,
    output logic                 o_RX_Busy
);

    localparam int              CNT_W     = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_BIT  = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_DONE
    } state_t;

    state_t               state_reg;
    logic                 rx_meta_reg;
    logic                 rx_sync_reg;
    logic [CNT_W-1:0]     clk_cnt_reg;
    logic [3:0]           bit_cnt_reg;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 parity_bit_reg;
    logic                 frame_err_reg;
    logic                 wait_high_reg;
    logic                 parity_calc;

    assign parity_calc = (^shift_reg) ^ parity_bit_reg;
    assign o_RX_Busy   = (state_reg != S_IDLE);

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_reg      <= S_IDLE;
            rx_meta_reg    <= 1'b1;
            rx_sync_reg    <= 1'b1;
            clk_cnt_reg    <= '0;
            bit_cnt_reg    <= '0;
            shift_reg      <= '0;
            parity_bit_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
            // After reset the line must be seen idle before a start bit is
            // accepted, so a frame cut by reset is never half-received.
            wait_high_reg  <= 1'b1;
            o_RX_Data      <= '0;
            o_RX_Done      <= 1'b0;
            o_Parity_Err   <= 1'b0;
            o_Frame_Err    <= 1'b0;
        end else begin
            rx_meta_reg <= i_RX_Serial;
            rx_sync_reg <= rx_meta_reg;
            o_RX_Done   <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    clk_cnt_reg   <= '0;
                    bit_cnt_reg   <= '0;
                    frame_err_reg <= 1'b0;
                    if (wait_high_reg) begin
                        if (rx_sync_reg) wait_high_reg <= 1'b0;
                    end else if (!rx_sync_reg) begin
                        state_reg <= S_START;
                    end
                end
                S_START: begin
                    if (clk_cnt_reg == HALF_BIT) begin
                        clk_cnt_reg <= '0;
                        state_reg   <= rx_sync_reg ? S_IDLE : S_DATA;
                    end else begin
                        clk_cnt_reg <= clk_cnt_reg + CNT_ONE;
                    end
                end
                S_DATA: begin
                    if (clk_cnt_reg == BIT_LAST) begin
                        clk_cnt_reg <= '0;
                        shift_reg   <= {rx_sync_reg, shift_reg[DATA_BITS-1:1]};
                        if (bit_cnt_reg == DATA_LAST) begin
                            bit_cnt_reg <= '0;
                            state_reg   <= (PARITY != 0) ? S_PAR : S_STOP;
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + 4'd1;
                        end
                    end else begin
                        clk_cnt_reg <= clk_cnt_reg + CNT_ONE;
                    end
                end
                S_PAR: begin
                    if (clk_cnt_reg == BIT_LAST) begin
                        clk_cnt_reg    <= '0;
                        parity_bit_reg <= rx_sync_reg;
                        state_reg      <= S_STOP;
                    end else begin
                        clk_cnt_reg <= clk_cnt_reg + CNT_ONE;
                    end
                end
                S_STOP: begin
                    if (clk_cnt_reg == BIT_LAST) begin
                        clk_cnt_reg <= '0;
                        if (!rx_sync_reg) frame_err_reg <= 1'b1;
                        if (bit_cnt_reg == STOP_LAST) begin
                            // A low last stop bit may be a break: hold off
                            // re-arming until the line goes high again.
                            wait_high_reg <= ~rx_sync_reg;
                            state_reg     <= S_DONE;
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + 4'd1;
                        end
                    end else begin
                        clk_cnt_reg <= clk_cnt_reg + CNT_ONE;
                    end
                end
                S_DONE: begin
                    o_RX_Done   <= 1'b1;
                    o_RX_Data   <= shift_reg;
                    o_Frame_Err <= frame_err_reg;
                    if (PARITY == 1)
                        o_Parity_Err <= parity_calc;
                    else if (PARITY == 2)
                        o_Parity_Err <= ~parity_calc;
                    else
                        o_Parity_Err <= 1'b0;
                    state_reg <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: 8N1, 8E1 and 7O2 instances share one
// clock and reset; received frames are checked against a scoreboard queue.
`timescale 1ns/1ps
module tb_uart_rx_param;

    localparam int BIT = 87;

    typedef struct packed {
        logic [8:0] data;
        logic       perr;
        logic       ferr;
    } frame_t;

    logic clk = 1'b0;
    always #50 clk = ~clk;

    logic rst_n = 1'b0;
    logic rx_a = 1'b1, rx_b = 1'b1, rx_c = 1'b1;

    logic [7:0] data_a, data_b;
    logic [6:0] data_c;
    logic done_a, perr_a, ferr_a, busy_a;
    logic done_b, perr_b, ferr_b, busy_b;
    logic done_c, perr_c, ferr_c, busy_c;

    uart_rx_param #(.CLKS_PER_BIT(BIT), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_a (
        .i_clock(clk), .i_reset_n(rst_n), .i_RX_Serial(rx_a),
        .o_RX_Data(data_a), .o_RX_Done(done_a), .o_Parity_Err(perr_a),
        .o_Frame_Err(ferr_a), .o_RX_Busy(busy_a));

    uart_rx_param #(.CLKS_PER_BIT(BIT), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_b (
        .i_clock(clk), .i_reset_n(rst_n), .i_RX_Serial(rx_b),
        .o_RX_Data(data_b), .o_RX_Done(done_b), .o_Parity_Err(perr_b),
        .o_Frame_Err(ferr_b), .o_RX_Busy(busy_b));

    uart_rx_param #(.CLKS_PER_BIT(BIT), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u_c (
        .i_clock(clk), .i_reset_n(rst_n), .i_RX_Serial(rx_c),
        .o_RX_Data(data_c), .o_RX_Done(done_c), .o_Parity_Err(perr_c),
        .o_Frame_Err(ferr_c), .o_RX_Busy(busy_c));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Output monitors: log every done pulse with its cycle, count busy cycles.
    frame_t obs_a[32], obs_b[32], obs_c[32];
    int     obs_cyc_a[32];
    int     cnt_a = 0, cnt_b = 0, cnt_c = 0;
    int     busy_cyc_a = 0;

    always @(negedge clk) begin
        if (done_a && cnt_a < 32) begin
            obs_a[cnt_a]     <= {9'(data_a), perr_a, ferr_a};
            obs_cyc_a[cnt_a] <= cyc;
            cnt_a            <= cnt_a + 1;
        end
        if (busy_a) busy_cyc_a <= busy_cyc_a + 1;
    end
    always @(negedge clk) begin
        if (done_b && cnt_b < 32) begin
            obs_b[cnt_b] <= {9'(data_b), perr_b, ferr_b};
            cnt_b        <= cnt_b + 1;
        end
    end
    always @(negedge clk) begin
        if (done_c && cnt_c < 32) begin
            obs_c[cnt_c] <= {9'(data_c), perr_c, ferr_c};
            cnt_c        <= cnt_c + 1;
        end
    end

    frame_t exp_q[$];
    int     rd_idx[3] = '{0, 0, 0};
    int     n_cmp = 0;
    int     n_bad = 0;

    function automatic int get_count(input int sel);
        case (sel)
            0:       return cnt_a;
            1:       return cnt_b;
            default: return cnt_c;
        endcase
    endfunction

    function automatic frame_t get_obs(input int sel, input int idx);
        case (sel)
            0:       return obs_a[idx];
            1:       return obs_b[idx];
            default: return obs_c[idx];
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_cmp++;
        assert (observed === expected) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic set_line(input int sel, input logic v);
        case (sel)
            0:       rx_a = v;
            1:       rx_b = v;
            default: rx_c = v;
        endcase
    endtask

    task automatic hold_bit(input int sel, input logic v);
        set_line(sel, v);
        repeat (BIT) @(negedge clk);
    endtask

    // Drives one frame starting at the current negedge and queues the expected result.
    task automatic send_frame(input int sel, input logic [8:0] d, input int nbits, input int par,
                              input bit bad_par, input int nstop, input bit bad_stop,
                              output int t0);
        frame_t e;
        logic   p;
        set_line(sel, 1'b0);
        t0 = cyc;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < nbits; i++) hold_bit(sel, d[i]);
        if (par != 0) begin
            p = (^d) ^ (par == 2) ^ bad_par;
            hold_bit(sel, p);
        end
        for (int s = 0; s < nstop; s++) hold_bit(sel, !(bad_stop && s == 0));
        set_line(sel, 1'b1);
        e.data = d;
        e.perr = (par != 0) && bad_par;
        e.ferr = bad_stop;
        exp_q.push_back(e);
    endtask

    task automatic expect_frames(input int sel, input int n, input string tag);
        int     t;
        frame_t e, o;
        t = 0;
        while (get_count(sel) < rd_idx[sel] + n && t < 4000) begin
            @(negedge clk);
            t++;
        end
        repeat (5) @(negedge clk);
        check({tag, "_ndone"}, get_count(sel), rd_idx[sel] + n);
        for (int k = 0; k < n; k++) begin
            e = exp_q.pop_front();
            if (rd_idx[sel] < get_count(sel)) begin
                o = get_obs(sel, rd_idx[sel]);
                check({tag, "_data"}, o.data, e.data);
                check({tag, "_perr"}, o.perr, e.perr);
                check({tag, "_ferr"}, o.ferr, e.ferr);
            end
            rd_idx[sel]++;
        end
        rd_idx[sel] = get_count(sel);
    endtask

    initial begin
        int     t0, base, busy0, lat;
        frame_t e;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_done", done_a, 0);
        check("rst_data", data_a, 0);
        check("rst_perr", perr_a, 0);
        check("rst_ferr", ferr_a, 0);
        check("rst_busy", busy_a, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // 8N1 clean frame, latency and busy window
        busy0 = busy_cyc_a;
        send_frame(0, 9'h3F, 8, 0, 0, 1, 0, t0);
        expect_frames(0, 1, "a_3F");
        lat = (rd_idx[0] > 0) ? obs_cyc_a[rd_idx[0] - 1] - t0 : 0;
        check("a_3F_latency_ok", (lat >= 828 && lat <= 831), 1);
        check("a_3F_busy_ok", (busy_cyc_a - busy0 >= 825 && busy_cyc_a - busy0 <= 829), 1);
        check("a_3F_busy_after", busy_a, 0);

        // 8N1 with low stop bit
        send_frame(0, 9'hA5, 8, 0, 0, 1, 1, t0);
        expect_frames(0, 1, "a_A5");

        // 20-clock glitch on the idle line is rejected
        base = cnt_a;
        set_line(0, 1'b0);
        repeat (20) @(negedge clk);
        set_line(0, 1'b1);
        repeat (45) @(negedge clk);
        check("glitch_busy", busy_a, 0);
        repeat (200) @(negedge clk);
        check("glitch_ndone", cnt_a, base);
        check("glitch_data", data_a, 8'hA5);
        check("glitch_ferr", ferr_a, 1);

        // Break: one frame with frame error, then no re-arm while low
        e.data = 9'h000; e.perr = 1'b0; e.ferr = 1'b1;
        exp_q.push_back(e);
        set_line(0, 1'b0);
        repeat (20 * BIT) @(negedge clk);
        expect_frames(0, 1, "break");
        check("break_busy", busy_a, 0);
        set_line(0, 1'b1);
        repeat (2 * BIT) @(negedge clk);
        send_frame(0, 9'h3C, 8, 0, 0, 1, 0, t0);
        expect_frames(0, 1, "a_3C");

        // Reset during data bit 3 of 0x55, frame abandoned, then clean 0x55
        base = cnt_a;
        hold_bit(0, 1'b0);
        hold_bit(0, 1'b1);
        hold_bit(0, 1'b0);
        hold_bit(0, 1'b1);
        set_line(0, 1'b0);
        repeat (40) @(negedge clk);
        rst_n = 1'b0;
        repeat (4) @(negedge clk);
        check("midrst_busy", busy_a, 0);
        check("midrst_data", data_a, 0);
        rst_n = 1'b1;
        repeat (43) @(negedge clk);
        set_line(0, 1'b1);
        repeat (3 * BIT) @(negedge clk);
        check("midrst_ndone", cnt_a, base);
        check("midrst_busy_idle", busy_a, 0);
        send_frame(0, 9'h55, 8, 0, 0, 1, 0, t0);
        expect_frames(0, 1, "a_55");

        // 8E1: wrong then correct parity
        send_frame(1, 9'hCD, 8, 1, 1, 1, 0, t0);
        expect_frames(1, 1, "b_CD_bad");
        send_frame(1, 9'hCD, 8, 1, 0, 1, 0, t0);
        expect_frames(1, 1, "b_CD_good");

        // 7O2 back-to-back frames
        send_frame(2, 9'h41, 7, 2, 0, 2, 0, t0);
        send_frame(2, 9'h7F, 7, 2, 0, 2, 0, t0);
        expect_frames(2, 2, "c_b2b");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
